// File: rtl/viterbi_pkg.sv
// Shared types, constants and the expected-symbol table for the Viterbi decoder.
package viterbi_pkg;

    localparam int unsigned NSTATES  = 8;
    localparam int unsigned STATE_W  = 3;
    localparam int unsigned METRIC_W = 2;
    localparam int unsigned PAIR_W   = 2;

    typedef logic [STATE_W-1:0]  state_t;
    typedef logic [METRIC_W-1:0] metric_t;
    typedef logic [PAIR_W-1:0]   pair_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_e;

    // Path-0 expected code pair for each trellis state; path 1 uses the complement.
    function automatic pair_t exp0(input state_t s);
        pair_t e;
        case (s)
            3'd0:    e = 2'b00;
            3'd1:    e = 2'b11;
            3'd2:    e = 2'b11;
            3'd3:    e = 2'b00;
            3'd4:    e = 2'b01;
            3'd5:    e = 2'b10;
            3'd6:    e = 2'b10;
            default: e = 2'b01;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/bmc_unit.sv
// Combinational Hamming branch-metric unit shared by all trellis states.
module bmc_unit
    import viterbi_pkg::*;
(
    input  pair_t   rx_pair,
    input  pair_t   exp_pair,
    output metric_t path_0_bmc,
    output metric_t path_1_bmc
);

    pair_t diff_0;
    pair_t diff_1;

    // Distances to the expected pair and to its complement.
    always_comb begin
        diff_0     = rx_pair ^ exp_pair;
        diff_1     = rx_pair ^ ~exp_pair;
        path_0_bmc = METRIC_W'({1'b0, diff_0[1]}) + METRIC_W'({1'b0, diff_0[0]});
        path_1_bmc = METRIC_W'({1'b0, diff_1[1]}) + METRIC_W'({1'b0, diff_1[0]});
    end

endmodule

// File: rtl/bmc_scheduler.sv
// Steps one latched symbol through all trellis states and tracks frame position.
module bmc_scheduler
    import viterbi_pkg::*;
#(
    parameter  int unsigned FRAME_LEN = 16,
    localparam int unsigned SYM_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_valid,
    output logic             rx_ready,
    input  pair_t            rx_pair,
    output logic             bm_valid,
    input  logic             bm_ready,
    output state_t           bm_state,
    output metric_t          path_0_bmc,
    output metric_t          path_1_bmc,
    output logic             bm_last,
    output logic             frame_done,
    output logic [SYM_W-1:0] sym_idx
);

    localparam state_t         LAST_STATE = STATE_W'(NSTATES - 1);
    localparam logic [SYM_W-1:0] LAST_SYM = SYM_W'(FRAME_LEN - 1);

    fsm_e             state_q, state_d;
    pair_t            rx_reg_q, rx_reg_d;
    state_t           idx_q, idx_d;
    logic [SYM_W-1:0] sym_idx_q, sym_idx_d;
    logic             frame_done_q, frame_done_d;

    metric_t          bmc_0;
    metric_t          bmc_1;

    // State register with synchronous reset; an in-flight symbol is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rx_reg_q     <= '0;
            idx_q        <= '0;
            sym_idx_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_reg_q     <= rx_reg_d;
            idx_q        <= idx_d;
            sym_idx_q    <= sym_idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state: accept in IDLE, advance on each accepted beat in RUN.
    always_comb begin
        state_d      = state_q;
        rx_reg_d     = rx_reg_q;
        idx_d        = idx_q;
        sym_idx_d    = sym_idx_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    state_d  = RUN;
                    rx_reg_d = rx_pair;
                    idx_d    = '0;
                end
            end
            RUN: begin
                if (bm_ready) begin
                    if (idx_q == LAST_STATE) begin
                        state_d = IDLE;
                        if (sym_idx_q == LAST_SYM) begin
                            sym_idx_d    = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            sym_idx_d = SYM_W'(sym_idx_q + 1'b1);
                        end
                    end else begin
                        idx_d = STATE_W'(idx_q + 1'b1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    bmc_unit u_bmc_unit (
        .rx_pair    (rx_reg_q),
        .exp_pair   (exp0(idx_q)),
        .path_0_bmc (bmc_0),
        .path_1_bmc (bmc_1)
    );

    // Outputs decoded from registers only; beat fields are zeroed outside RUN.
    always_comb begin
        rx_ready   = (state_q == IDLE);
        bm_valid   = (state_q == RUN);
        bm_state   = bm_valid ? idx_q : '0;
        path_0_bmc = bm_valid ? bmc_0 : '0;
        path_1_bmc = bm_valid ? bmc_1 : '0;
        bm_last    = bm_valid && (idx_q == LAST_STATE);
        frame_done = frame_done_q;
        sym_idx    = sym_idx_q;
    end

endmodule

// File: tb/tb_bmc_scheduler.sv
// Directed and randomized checks of bmc_scheduler against a symbol-level model.
module tb_bmc_scheduler;

    localparam int FL = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [1:0] rx_pair;
    logic       bm_ready;

    logic       rx_ready, bm_valid, bm_last, frame_done;
    logic [2:0] bm_state;
    logic [1:0] path_0_bmc, path_1_bmc;
    logic [1:0] sym_idx;

    logic       u1_rx_ready, u1_bm_valid, u1_bm_last, u1_frame_done;
    logic [2:0] u1_bm_state;
    logic [1:0] u1_path_0_bmc, u1_path_1_bmc;
    logic [0:0] u1_sym_idx;

    int n_assert = 0;
    int n_fail   = 0;
    int sym_count = 0;

    logic [1:0] exp0_tab [8] = '{2'b00, 2'b11, 2'b11, 2'b00, 2'b01, 2'b10, 2'b10, 2'b01};

    always #5 clk = ~clk;

    bmc_scheduler #(.FRAME_LEN(FL)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_pair(rx_pair), .bm_valid(bm_valid), .bm_ready(bm_ready),
        .bm_state(bm_state), .path_0_bmc(path_0_bmc), .path_1_bmc(path_1_bmc),
        .bm_last(bm_last), .frame_done(frame_done), .sym_idx(sym_idx)
    );

    bmc_scheduler #(.FRAME_LEN(1)) dut1 (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_ready(u1_rx_ready),
        .rx_pair(rx_pair), .bm_valid(u1_bm_valid), .bm_ready(bm_ready),
        .bm_state(u1_bm_state), .path_0_bmc(u1_path_0_bmc), .path_1_bmc(u1_path_1_bmc),
        .bm_last(u1_bm_last), .frame_done(u1_frame_done), .sym_idx(u1_sym_idx)
    );

    function automatic logic [31:0] hd(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return 32'(x[0]) + 32'(x[1]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input bit exp_fd, input bit exp_fd1);
        chk({tag, " rx_ready"},   32'(rx_ready),   32'd1);
        chk({tag, " bm_valid"},   32'(bm_valid),   32'd0);
        chk({tag, " bm_state"},   32'(bm_state),   32'd0);
        chk({tag, " path_0"},     32'(path_0_bmc), 32'd0);
        chk({tag, " path_1"},     32'(path_1_bmc), 32'd0);
        chk({tag, " bm_last"},    32'(bm_last),    32'd0);
        chk({tag, " frame_done"}, 32'(frame_done), 32'(exp_fd));
        chk({tag, " sym_idx"},    32'(sym_idx),    32'(sym_count % FL));
        chk({tag, " fl1 frame_done"}, 32'(u1_frame_done), 32'(exp_fd1));
        chk({tag, " fl1 sym_idx"},    32'(u1_sym_idx),    32'd0);
    endtask

    task automatic check_beat(input int s, input logic [1:0] pair);
        string t;
        t = $sformatf("beat s%0d pair%0b", s, pair);
        chk({t, " bm_valid"},   32'(bm_valid),   32'd1);
        chk({t, " bm_state"},   32'(bm_state),   32'(s));
        chk({t, " path_0"},     32'(path_0_bmc), hd(pair, exp0_tab[s]));
        chk({t, " path_1"},     32'(path_1_bmc), hd(pair, ~exp0_tab[s]));
        chk({t, " bm_last"},    32'(bm_last),    32'(s == 7));
        chk({t, " rx_ready"},   32'(rx_ready),   32'd0);
        chk({t, " frame_done"}, 32'(frame_done), 32'd0);
        chk({t, " sym_idx"},    32'(sym_idx),    32'(sym_count % FL));
        chk({t, " fl1 frame_done"}, 32'(u1_frame_done), 32'd0);
        chk({t, " fl1 bm_state"},   32'(u1_bm_state),   32'(s));
    endtask

    // Drives one symbol from the accepting edge to the return to IDLE.
    // abort_at >= 0 pulses reset while that state's beat is presented.
    task automatic do_symbol(input logic [1:0] pair, input int stall_state,
                             input int stall_len, input bit toggle, input int abort_at);
        bit stalled;
        bit fd_exp;
        chk("pre-accept rx_ready", 32'(rx_ready), 32'd1);
        rx_valid = 1'b1;
        rx_pair  = pair;
        bm_ready = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k <= ((s == stall_state) ? stall_len : 0); k++) begin
                stalled = (s == stall_state) && (k < stall_len);
                check_beat(s, pair);
                if (s == abort_at) begin
                    reset = 1'b1;
                    @(negedge clk);
                    reset = 1'b0;
                    sym_count = 0;
                    check_idle("after abort", 1'b0, 1'b0);
                    @(negedge clk);
                    check_idle("after abort +1", 1'b0, 1'b0);
                    return;
                end
                bm_ready = !stalled;
                if (toggle && !(s == 7 && !stalled)) begin
                    rx_valid = 1'($urandom);
                    rx_pair  = 2'($urandom);
                end else begin
                    rx_valid = 1'b0;
                end
                @(negedge clk);
            end
        end
        rx_valid = 1'b0;
        bm_ready = 1'b1;
        fd_exp = ((sym_count % FL) == FL - 1);
        sym_count++;
        check_idle($sformatf("end sym %0d", sym_count), fd_exp, 1'b1);
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_pair  = 2'b00;
        bm_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("in reset", 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_idle("after reset", 1'b0, 1'b0);

        // Directed patterns from the expected-symbol table.
        do_symbol(2'b00, -1, 0, 1'b0, -1);
        do_symbol(2'b11, -1, 0, 1'b0, -1);
        do_symbol(2'b10, -1, 0, 1'b0, -1);

        // Backpressure at state 3 for 4 cycles with rx_valid noise; closes frame.
        do_symbol(2'b01, 3, 4, 1'b1, -1);

        // Eight back-to-back symbols: two frame boundaries.
        for (int i = 0; i < 8; i++)
            do_symbol(2'($urandom), -1, 0, 1'b0, -1);

        // Reach frame symbol 3, then reset during state 5.
        for (int i = 0; i < 3; i++)
            do_symbol(2'($urandom), -1, 0, 1'b0, -1);
        do_symbol(2'b10, -1, 0, 1'b0, 5);
        do_symbol(2'b11, -1, 0, 1'b0, -1);

        // Randomized traffic with random stalls and idle gaps.
        for (int i = 0; i < 40; i++) begin
            do_symbol(2'($urandom), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 3)), 1'($urandom), -1);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check_idle("gap", 1'b0, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
